fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined core. It replaces the single-entry fetch path, which stalls the whole pipe while the ibus is busy, with a DEPTH-entry instruction queue between the ibus and decode. It owns the fetch PC and handles branch/jump redirects, including discarding a response still in flight. It also traps misaligned fetch PCs without issuing a bus request.

---
 rtl/fetch_queue.sv | 159 +++++++++++++++
 tb/tb_fetch_queue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Summary  : Instruction-fetch front end with a DEPTH-entry queue to decode,
//            redirect handling, in-flight response drop and misaligned trap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [ILEN-1:0] iresp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic            out_fault
);

  localparam int                c_ptr_w    = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]  c_full_cnt = (c_ptr_w + 1)'(DEPTH);
  localparam logic [XLEN-1:0]   c_step     = XLEN'(4);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [XLEN-1:0]     r_fetch_pc, w_fetch_pc_nxt;
  logic [XLEN-1:0]     r_inflight_pc;
  logic [XLEN-1:0]     r_pc_mem    [DEPTH];
  logic [ILEN-1:0]     r_instr_mem [DEPTH];
  logic [DEPTH-1:0]    r_fault_mem;
  logic [c_ptr_w-1:0]  r_rd_ptr, r_wr_ptr;
  logic [c_ptr_w:0]    r_count;

  logic w_full, w_req, w_push, w_push_fault, w_pop, w_flush;

  assign w_full = (r_count == c_full_cnt);
  assign w_pop  = out_valid & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req          = 1'b0;
    w_push         = 1'b0;
    w_push_fault   = 1'b0;
    w_flush        = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (redirect_valid) begin
          w_flush        = 1'b1;
          w_fetch_pc_nxt = redirect_pc;
        end else if (!w_full) begin
          if (r_fetch_pc[1:0] != 2'b00) begin
            w_push       = 1'b1;
            w_push_fault = 1'b1;
            w_state_nxt  = ST_HALT;
          end else begin
            w_req = 1'b1;
            if (iresp_data_ok) begin
              w_push         = 1'b1;
              w_fetch_pc_nxt = r_fetch_pc + c_step;
            end else begin
              w_state_nxt = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        w_req = 1'b1;
        if (redirect_valid) begin
          // A response arriving with the redirect is stale and simply dropped.
          w_flush        = 1'b1;
          w_fetch_pc_nxt = redirect_pc;
          w_state_nxt    = iresp_data_ok ? ST_RUN : ST_DROP;
        end else if (iresp_data_ok) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = r_fetch_pc + c_step;
          w_state_nxt    = ST_RUN;
        end
      end
      ST_DROP: begin
        w_req = 1'b1;
        if (redirect_valid) w_fetch_pc_nxt = redirect_pc;
        if (iresp_data_ok)  w_state_nxt    = ST_RUN;
      end
      ST_HALT: begin
        if (redirect_valid) begin
          w_flush        = 1'b1;
          w_fetch_pc_nxt = redirect_pc;
          w_state_nxt    = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // The in-flight register keeps the bus address stable after fetch_pc moves on.
  assign ireq_valid = w_req & ~reset;
  assign ireq_addr  = (r_state == ST_RUN) ? r_fetch_pc : r_inflight_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      if (w_req && (r_state == ST_RUN)) r_inflight_pc <= r_fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_count  <= '0;
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      if (w_push && !w_pop)      r_count <= r_count + (c_ptr_w + 1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (c_ptr_w + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
      r_instr_mem[r_wr_ptr] <= w_push_fault ? '0 : iresp_data;
      r_fault_mem[r_wr_ptr] <= w_push_fault;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr] : '0;
  assign out_fault = out_valid & r_fault_mem[r_rd_ptr];
  assign out_instr = (out_valid && !r_fault_mem[r_rd_ptr]) ? r_instr_mem[r_rd_ptr] : '0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module   : tb_fetch_queue
// Summary  : Self-checking bench for fetch_queue: vector table plus scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_queue;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  fetch_queue #(.DEPTH(4), .XLEN(64), .ILEN(32), .RESET_PC(64'h8000_0000)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return lo * 32'd3 + 32'h0000_1001;
  endfunction

  // Bus memory model: the word at the requested address.
  assign iresp_data = instr_of(ireq_addr);

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        fault;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    bit          rst;
    bit          dok;
    bit          rdy;
    bit          erv;
    logic [63:0] era;
    bit          eov;
    logic [63:0] eopc;
  } vec_t;
  vec_t vt[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic sbp(input logic [63:0] pc, input logic fault);
    sb_t e;
    e.pc    = pc;
    e.instr = fault ? 32'h0 : instr_of(pc);
    e.fault = fault;
    sb_q.push_back(e);
  endtask

  // One cycle: drive at negedge, settle, then retire any accepted head.
  task automatic drive(input logic dok, input logic rdy, input logic rv, input logic [63:0] rpc);
    @(negedge clk);
    iresp_data_ok  = dok;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    if (out_valid === 1'b1 && rdy) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_extra: got pc %h expected no output", out_pc);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_instr", {32'h0, out_instr}, {32'h0, e.instr});
        chkb("sb_fault", out_fault, e.fault);
      end
    end
  endtask

  task automatic expect_req(input logic v, input logic [63:0] a);
    chkb("req_valid", ireq_valid, v);
    if (v) chk("req_addr", ireq_addr, a);
  endtask

  task automatic expect_out(input logic v, input logic [63:0] pc);
    chkb("out_valid", out_valid, v);
    if (v) chk("out_pc", out_pc, pc);
  endtask

  // Asserts reset now (possibly mid-cycle) and releases it just after a posedge.
  task automatic do_reset();
    reset          = 1'b1;
    iresp_data_ok  = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    chkb("rst_req_valid", ireq_valid, 1'b0);
    chkb("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_out_instr", {32'h0, out_instr}, 64'h0);
    chkb("rst_out_fault", out_fault, 1'b0);
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic addv(input bit r, input bit d, input bit y, input bit erv,
                      input logic [63:0] era, input bit eov, input logic [63:0] eopc);
    vec_t v;
    v.rst = r; v.dok = d; v.rdy = y; v.erv = erv;
    v.era = era; v.eov = eov; v.eopc = eopc;
    vt.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    iresp_data_ok  = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Zero-wait streaming, one stall, then fill-to-full and drain.
    addv(1, 1, 1, 1, RST_PC + 64'h00, 0, 64'h0);
    addv(0, 1, 1, 1, RST_PC + 64'h04, 1, RST_PC + 64'h00);
    addv(0, 1, 1, 1, RST_PC + 64'h08, 1, RST_PC + 64'h04);
    addv(0, 1, 1, 1, RST_PC + 64'h0C, 1, RST_PC + 64'h08);
    addv(0, 0, 1, 1, RST_PC + 64'h10, 1, RST_PC + 64'h0C);
    addv(0, 1, 1, 1, RST_PC + 64'h10, 0, 64'h0);
    addv(0, 1, 1, 1, RST_PC + 64'h14, 1, RST_PC + 64'h10);
    addv(1, 1, 0, 1, RST_PC + 64'h00, 0, 64'h0);
    addv(0, 1, 0, 1, RST_PC + 64'h04, 1, RST_PC + 64'h00);
    addv(0, 1, 0, 1, RST_PC + 64'h08, 1, RST_PC + 64'h00);
    addv(0, 1, 0, 1, RST_PC + 64'h0C, 1, RST_PC + 64'h00);
    addv(0, 0, 0, 0, 64'h0,           1, RST_PC + 64'h00);
    addv(0, 0, 1, 0, 64'h0,           1, RST_PC + 64'h00);
    addv(0, 1, 1, 1, RST_PC + 64'h10, 1, RST_PC + 64'h04);
    addv(0, 1, 1, 1, RST_PC + 64'h14, 1, RST_PC + 64'h08);
    addv(0, 1, 1, 1, RST_PC + 64'h18, 1, RST_PC + 64'h0C);
    addv(0, 1, 1, 1, RST_PC + 64'h1C, 1, RST_PC + 64'h10);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst) do_reset();
      drive(vt[i].dok, vt[i].rdy, 1'b0, 64'h0);
      expect_req(vt[i].erv, vt[i].era);
      expect_out(vt[i].eov, vt[i].eopc);
      if (vt[i].dok && vt[i].erv) sbp(vt[i].era, 1'b0);
    end

    // Redirect while a request stalls: in-flight response is discarded.
    do_reset();
    drive(1, 1, 0, 0);                 expect_req(1, RST_PC);        sbp(RST_PC, 0);
    drive(1, 1, 0, 0);                 expect_req(1, RST_PC + 4);    sbp(RST_PC + 4, 0);
    drive(0, 1, 0, 0);                 expect_req(1, RST_PC + 8);
    drive(0, 1, 1, RST_PC + 64'h100);  expect_req(1, RST_PC + 8);    expect_out(0, 0);
    drive(0, 1, 0, 0);                 expect_req(1, RST_PC + 8);    expect_out(0, 0);
    drive(1, 1, 0, 0);                 expect_req(1, RST_PC + 8);    expect_out(0, 0);
    drive(1, 1, 0, 0);                 expect_req(1, RST_PC + 64'h100); expect_out(0, 0);
    sbp(RST_PC + 64'h100, 0);
    drive(0, 1, 0, 0);                 expect_req(1, RST_PC + 64'h104); expect_out(1, RST_PC + 64'h100);

    // Redirect with data_ok in the same cycle, then RUN redirect and PC wrap.
    do_reset();
    drive(0, 1, 0, 0);                 expect_req(1, RST_PC);
    drive(1, 1, 1, RST_PC + 64'h200);  expect_req(1, RST_PC);        expect_out(0, 0);
    drive(1, 1, 0, 0);                 expect_req(1, RST_PC + 64'h200); expect_out(0, 0);
    sbp(RST_PC + 64'h200, 0);
    drive(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    expect_req(0, 0);                  expect_out(1, RST_PC + 64'h200);
    drive(1, 1, 0, 0);                 expect_req(1, 64'hFFFF_FFFF_FFFF_FFFC); expect_out(0, 0);
    sbp(64'hFFFF_FFFF_FFFF_FFFC, 0);
    drive(0, 1, 0, 0);                 expect_req(1, 64'h0);         expect_out(1, 64'hFFFF_FFFF_FFFF_FFFC);

    // Misaligned redirect traps into HALT until another redirect.
    do_reset();
    drive(0, 0, 1, RST_PC + 64'h102);  expect_req(0, 0);
    drive(0, 0, 0, 0);                 expect_req(0, 0);             expect_out(0, 0);
    sbp(RST_PC + 64'h102, 1);
    drive(0, 0, 0, 0);                 expect_req(0, 0);             expect_out(1, RST_PC + 64'h102);
    chkb("fault_flag", out_fault, 1'b1);
    chk("fault_instr", {32'h0, out_instr}, 64'h0);
    drive(0, 1, 0, 0);                 expect_req(0, 0);
    drive(0, 1, 0, 0);                 expect_req(0, 0);             expect_out(0, 0);
    drive(0, 1, 1, RST_PC + 64'h200);  expect_req(0, 0);
    drive(1, 1, 0, 0);                 expect_req(1, RST_PC + 64'h200);
    sbp(RST_PC + 64'h200, 0);
    drive(0, 1, 0, 0);                 expect_out(1, RST_PC + 64'h200);

    // Full queue, pops, then reset while a request waits.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      expect_req(1, RST_PC + 64'(4 * i));
      sbp(RST_PC + 64'(4 * i), 0);
    end
    drive(0, 1, 0, 0);                 expect_req(0, 0);             expect_out(1, RST_PC);
    drive(0, 1, 0, 0);                 expect_req(1, RST_PC + 64'h10); expect_out(1, RST_PC + 4);
    drive(0, 0, 0, 0);                 expect_req(1, RST_PC + 64'h10); expect_out(1, RST_PC + 8);
    do_reset();
    drive(1, 1, 0, 0);                 expect_req(1, RST_PC);        expect_out(0, 0);
    sbp(RST_PC, 0);
    drive(0, 1, 0, 0);                 expect_out(1, RST_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
